// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with
// valid/ready handshakes on request and result sides.
// Optional build macro: MDU_FAST_SPECIAL_EN. When defined, divide-by-zero,
// signed overflow and any op with a zero operand go straight to DONE.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
`ifdef MDU_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
    return ~v + PW'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] spec_val_q, spec_val_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             spec_q, spec_d;

  logic             accept, is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic             div0, ovf, zero_op, spec_hit;
  logic [WIDTH-1:0] a_mag, b_mag, spec_val;
  logic [WIDTH:0]   mul_sum, div_rsh, div_diff;
  logic [PW-1:0]    step, fin_prod;
  logic [WIDTH-1:0] fin_sel, fin_res;

  // Request decode: operand magnitudes, result sign and special cases.
  always_comb begin
    accept   = in_valid && (state_q == S_IDLE) && !flush;
    is_div   = op[2];
    sgn_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = sgn_a && a[WIDTH-1];
    b_neg    = sgn_b && b[WIDTH-1];
    a_mag    = a_neg ? neg_w(a) : a;
    b_mag    = b_neg ? neg_w(b) : b;
    div0     = is_div && (b == '0);
    ovf      = is_div && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
    zero_op  = (a == '0) || (b == '0);
    spec_hit = div0 || ovf || (FAST && zero_op);
    spec_val = '0;
    if (div0)     spec_val = op[1] ? a : ALL_ONES;
    else if (ovf) spec_val = op[1] ? '0 : a;
  end

  // One radix-2 iteration plus sign fixup of the final value.
  always_comb begin
    mul_sum  = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, dvsr_q} : '0);
    div_rsh  = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
    div_diff = div_rsh - {1'b0, dvsr_q};
    if (op_q[2]) begin
      // Restoring divide: remainder in the high half, quotient shifts into the low half.
      if (div_diff[WIDTH]) step = {div_rsh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      // Shift-add multiply: multiplier sits in the low half and drains out to the right.
      step = {mul_sum, prod_q[WIDTH-1:1]};
    end
    fin_prod = neg_q ? neg_p(step) : step;
    fin_sel  = op_q[1] ? step[PW-1:WIDTH] : step[WIDTH-1:0];
    if (spec_q)                 fin_res = spec_val_q;
    else if (op_q[2])           fin_res = neg_q ? neg_w(fin_sel) : fin_sel;
    else if (op_q[1:0] == 2'b00) fin_res = fin_prod[WIDTH-1:0];
    else                        fin_res = fin_prod[PW-1:WIDTH];
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid) state_d = (FAST && spec_hit) ? S_DONE : S_BUSY;
        S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath register updates: load at accept, iterate while busy.
  always_comb begin
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    dvsr_d     = dvsr_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    op_d       = op_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    if (accept) begin
      op_d       = op;
      neg_d      = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
      spec_d     = spec_hit;
      spec_val_d = spec_val;
      cnt_d      = CW'(WIDTH - 1);
      prod_d     = is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      dvsr_d     = is_div ? b_mag : a_mag;
      if (FAST && spec_hit) result_d = spec_val;
    end else if ((state_q == S_BUSY) && !flush) begin
      prod_d = step;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else             result_d = fin_res;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      dvsr_q     <= '0;
      spec_val_q <= '0;
      result_q   <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      dvsr_q     <= dvsr_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: table-driven, randomized and hand-sequenced checks of mdu_iterative.
module tb_mdu_iterative;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] result;

  int nchk = 0;
  int nerr = 0;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the RV32M arithmetic definitions.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (o)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : 32'(ux % uy);
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MDU_FAST_SPECIAL_EN
    if (x == 0 || y == 0) return 1;
    if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`else
    if (o == 3'd7 && x == 0) return W + 1;
`endif
    return W + 1;
  endfunction

  // Issue one op with out_ready high; lat counts clock edges from the accept edge
  // (inclusive) up to the first edge after which out_valid is seen.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output int lat, output bit busy_ok);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 4 * W + 8) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [W-1:0] res, x, y;
    logic [2:0]   o;
    int           lat;
    bit           busy_ok;

    tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[4]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[5]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    tbl[7]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[8]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[9]  = '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234};
    tbl[10] = '{3'd5, 32'd100,       32'd7,         32'd14};
    tbl[11] = '{3'd7, 32'd100,       32'd7,         32'd2};
    tbl[12] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    tbl[13] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1};
    tbl[14] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    tbl[15] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    tbl[16] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[17] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, busy_ok);
      chk($sformatf("vec%0d result", i), res, tbl[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)));
      if (i == 0) chk("vec0 in_ready low while busy", 32'(busy_ok), 32'd1);
    end

    // Randomized operands with corner-value bias
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: x = '0;
        1: x = '1;
        2: x = 32'h8000_0000;
        3: x = 32'($urandom_range(0, 20));
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = '1;
        2: y = 32'h8000_0000;
        3: y = 32'($urandom_range(0, 20));
        default: y = $urandom;
      endcase
      run_op(o, x, y, res, lat, busy_ok);
      chk($sformatf("rnd%0d op%0d a=%08h b=%08h", i, o, x, y), res, model(o, x, y));
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(exp_lat(o, x, y)));
    end

    // Result held while consumer stalls; new requests ignored meanwhile
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * W + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold latency", 32'(lat), 32'(W + 1));
    in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d result", i), result, 32'd14);
      chk($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 32'(out_valid), 32'd0);
    chk("release in_ready", 32'(in_ready), 32'd1);
    chk("release result kept", result, 32'd14);

    // Flush in the fifth BUSY cycle, then a request on the first IDLE cycle
    in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush result kept", result, 32'd14);
    run_op(3'd5, 32'd50, 32'd5, res, lat, busy_ok);
    chk("after flush result", res, 32'd10);
    chk("after flush latency", 32'(lat), 32'(W + 1));

    // Request coinciding with flush is dropped
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+req not accepted", 32'(in_ready), 32'd1);

    // Flush while a result is waiting
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * W + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done result", result, 32'd42);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush done out_valid", 32'(out_valid), 32'd0);
    chk("flush done in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-BUSY, then a request on the first IDLE cycle
    in_valid = 1'b1; op = 3'd3; a = 32'hFFFF_0000; b = 32'h1234_5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset result", result, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat, busy_ok);
    chk("after reset result", res, 32'hFFFF_FFFF);
    chk("after reset latency", 32'(lat), 32'(W + 1));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
